request_unit: RTL and testbench

REQUEST_UNIT -- requirements
Module: request_unit

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/link_reg.sv | 51 +++++
 rtl/request_unit.sv | 100 ++++++++++
 tb/tb_request_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, request-unit FSM states and the word-address
// comparison used for the LL/SC reservation.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } ru_state_t;

  // Reservations are word-granular: the two byte-offset bits are ignored.
  localparam int WORD_LSB = 2;

  function automatic logic same_word(input word_t a, input word_t b);
    return a[31:WORD_LSB] == b[31:WORD_LSB];
  endfunction

endpackage

// File: rtl/link_reg.sv
// LL/SC reservation register: holds the linked address and its valid bit,
// and compares it against the current data address and the snoop address.
module link_reg
  import cpu_types_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  logic  clear_i,
  input  word_t addr_i,
  input  logic  snoop_valid_i,
  input  word_t snoop_addr_i,
  output logic  link_valid_o,
  output logic  addr_match_o,
  output logic  snoop_hit_o
);

  word_t link_addr_q, link_addr_d;
  logic  link_valid_q, link_valid_d;
  logic  unused_lsbs;

  assign addr_match_o = same_word(addr_i, link_addr_q);
  assign snoop_hit_o  = snoop_valid_i & link_valid_q & same_word(snoop_addr_i, link_addr_q);
  assign link_valid_o = link_valid_q;

  // A completing LL overrides a snoop or SC clear arriving in the same cycle.
  always_comb begin
    link_addr_d  = link_addr_q;
    link_valid_d = link_valid_q;
    if (clear_i || snoop_hit_o) begin
      link_valid_d = 1'b0;
    end
    if (load_i) begin
      link_valid_d = 1'b1;
      link_addr_d  = addr_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      link_addr_q  <= '0;
      link_valid_q <= 1'b0;
    end else begin
      link_addr_q  <= link_addr_d;
      link_valid_q <= link_valid_d;
    end
  end

  assign unused_lsbs = ^{link_addr_q[1:0], addr_i[1:0], snoop_addr_i[1:0]};

endmodule

// File: rtl/request_unit.sv
// Memory request sequencer: fetch, optional data access (with LL/SC
// reservation checking) and sticky halt. Outputs decode from state and inputs.
module request_unit
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  logic  dhit,
  input  logic  DatRead,
  input  logic  DatWrite,
  input  logic  Ll,
  input  logic  Sc,
  input  logic  Halt,
  input  word_t daddr,
  input  logic  snoop_valid,
  input  word_t snoop_addr,
  output logic  imemREN,
  output logic  dmemREN,
  output logic  dmemWEN,
  output logic  pc_en,
  output logic  sc_ok,
  output logic  link_valid,
  output logic  halted
);

  ru_state_t state_q, state_d;
  logic      link_load, link_clear;
  logic      addr_match, snoop_hit;
  logic      sc_fail;

  link_reg u_link_reg (
    .clk_i         (CLK),
    .rst_i         (RST),
    .load_i        (link_load),
    .clear_i       (link_clear),
    .addr_i        (daddr),
    .snoop_valid_i (snoop_valid),
    .snoop_addr_i  (snoop_addr),
    .link_valid_o  (link_valid),
    .addr_match_o  (addr_match),
    .snoop_hit_o   (snoop_hit)
  );

  // An SC fails without touching memory if the reservation is gone, points
  // elsewhere, or is being invalidated right now.
  assign sc_fail = Sc & (~link_valid | ~addr_match | snoop_hit);
  assign halted  = (state_q == HALTED);

  always_comb begin
    state_d    = state_q;
    imemREN    = 1'b0;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    pc_en      = 1'b0;
    sc_ok      = 1'b0;
    link_load  = 1'b0;
    link_clear = 1'b0;
    unique case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          if (Halt) begin
            state_d = HALTED;
          end else if (DatRead || DatWrite) begin
            state_d = DATA;
          end else begin
            pc_en = ~RST;
          end
        end
      end
      DATA: begin
        dmemREN = DatRead;
        dmemWEN = DatWrite & ~sc_fail;
        if (sc_fail || dhit) begin
          pc_en      = ~RST;
          sc_ok      = Sc & ~sc_fail & ~RST;
          state_d    = FETCH;
          link_clear = Sc;
          link_load  = Ll & dhit & ~Sc;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_request_unit.sv
// Randomized bench for request_unit against a transaction-level model of
// fetch / data / halt behaviour and the LL/SC reservation.
module tb_request_unit;

  logic        CLK, RST;
  logic        ihit, dhit, DatRead, DatWrite, Ll, Sc, Halt, snoop_valid;
  logic [31:0] daddr, snoop_addr;
  logic        imemREN, dmemREN, dmemWEN, pc_en, sc_ok, link_valid, halted;

  request_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .dhit        (dhit),
    .DatRead     (DatRead),
    .DatWrite    (DatWrite),
    .Ll          (Ll),
    .Sc          (Sc),
    .Halt        (Halt),
    .daddr       (daddr),
    .snoop_valid (snoop_valid),
    .snoop_addr  (snoop_addr),
    .imemREN     (imemREN),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .pc_en       (pc_en),
    .sc_ok       (sc_ok),
    .link_valid  (link_valid),
    .halted      (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  localparam int I_NOP = 0, I_LW = 1, I_SW = 2, I_LL = 3, I_SC = 4, I_HALT = 5;

  // Model: which phase the current instruction is in, plus the reservation.
  bit          m_in_data, m_halted, m_resv;
  logic [29:0] m_word;
  int          instr, halt_cycles;
  logic [31:0] addr_tab [5];

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_imemREN"},    imemREN,    1);
    check_eq({tag, "_dmemREN"},    dmemREN,    0);
    check_eq({tag, "_dmemWEN"},    dmemWEN,    0);
    check_eq({tag, "_pc_en"},      pc_en,      0);
    check_eq({tag, "_sc_ok"},      sc_ok,      0);
    check_eq({tag, "_link_valid"}, link_valid, 0);
    check_eq({tag, "_halted"},     halted,     0);
  endtask

  task automatic model_reset();
    m_in_data   = 0;
    m_halted    = 0;
    m_resv      = 0;
    m_word      = '0;
    halt_cycles = 0;
  endtask

  task automatic pick_inputs();
    int r;
    if (!m_in_data) begin
      r = $urandom_range(0, 99);
      instr = (r < 2) ? I_HALT : (r < 30) ? I_NOP : (r < 45) ? I_LW :
              (r < 60) ? I_SW : (r < 80) ? I_LL : I_SC;
      if (instr == I_SC && m_resv && $urandom_range(0, 9) < 7)
        daddr = {m_word, 2'($urandom_range(0, 3))};
      else
        daddr = addr_tab[$urandom_range(0, 4)];
    end
    DatRead     = (instr == I_LW) || (instr == I_LL);
    DatWrite    = (instr == I_SW) || (instr == I_SC);
    Ll          = (instr == I_LL);
    Sc          = (instr == I_SC);
    Halt        = (instr == I_HALT);
    ihit        = 1'($urandom_range(0, 1));
    dhit        = ($urandom_range(0, 9) < 4);
    snoop_valid = ($urandom_range(0, 9) < 2);
    if (m_resv && $urandom_range(0, 1) == 1)
      snoop_addr = {m_word, 2'($urandom_range(0, 3))};
    else
      snoop_addr = addr_tab[$urandom_range(0, 4)];
  endtask

  task automatic check_and_advance();
    bit e_imem, e_dren, e_dwen, e_pc, e_sc, kill, fail, mem_op;
    e_imem = 0; e_dren = 0; e_dwen = 0; e_pc = 0; e_sc = 0; fail = 0;
    mem_op = DatRead || DatWrite;
    kill   = snoop_valid && m_resv && (snoop_addr[31:2] == m_word);
    if (m_halted) begin
      // nothing requested
    end else if (!m_in_data) begin
      e_imem = 1;
      e_pc   = ihit && !Halt && !mem_op;
    end else begin
      fail   = Sc && !(m_resv && daddr[31:2] == m_word && !kill);
      e_dren = DatRead;
      e_dwen = DatWrite && !fail;
      e_pc   = fail || dhit;
      e_sc   = Sc && dhit && !fail;
    end
    check_eq("imemREN",    imemREN,    e_imem);
    check_eq("dmemREN",    dmemREN,    e_dren);
    check_eq("dmemWEN",    dmemWEN,    e_dwen);
    check_eq("pc_en",      pc_en,      e_pc);
    check_eq("sc_ok",      sc_ok,      e_sc);
    check_eq("link_valid", link_valid, m_resv);
    check_eq("halted",     halted,     m_halted);

    if (kill) m_resv = 0;
    if (m_in_data && Sc && e_pc) m_resv = 0;
    if (m_in_data && Ll && dhit) begin
      m_resv = 1;
      m_word = daddr[31:2];
    end
    if (m_halted) begin
      halt_cycles++;
    end else if (!m_in_data) begin
      if (ihit && Halt) m_halted = 1;
      else if (ihit && mem_op) m_in_data = 1;
    end else if (e_pc) begin
      m_in_data = 0;
    end
  endtask

  initial begin
    addr_tab[0] = 32'h0000_0200;
    addr_tab[1] = 32'h0000_0204;
    addr_tab[2] = 32'h0000_0202;
    addr_tab[3] = 32'h0000_0100;
    addr_tab[4] = 32'h0000_0203;
    RST = 1'b1;
    ihit = 0; dhit = 0; DatRead = 0; DatWrite = 0; Ll = 0; Sc = 0; Halt = 0;
    daddr = '0; snoop_valid = 0; snoop_addr = '0;
    instr = I_NOP;
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge CLK);
    RST = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge CLK);
      RST = 1'b0;
      pick_inputs();
      #1;
      check_and_advance();
      // Occasionally yank reset between edges: mid-access, or to leave halt.
      if (halt_cycles >= 22 || (m_in_data && $urandom_range(0, 24) == 0)) begin
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
